// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the mini_cpu pipeline.
//   XLEN             - datapath / address width
//   PC_STEP          - fetch address increment per instruction
//   RESET_PC_DEFAULT - default first fetch address after reset
//   NOP_INSTR        - canonical NOP (addi x0, x0, 0) for IF/ID consumers
//   fetch_entry_t    - {pc, instr} pair carried through the fetch buffer
//   align_word()     - forces an address onto a word boundary
package cpu_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory request/response bus.
//   req    - fetch request valid (master -> slave)
//   addr   - word-aligned fetch address (master -> slave)
//   gnt    - request accepted this cycle (slave -> master)
//   rvalid - read data valid, in request order (slave -> master)
//   rdata  - instruction word (slave -> master)
interface if_fetch_if;
    import cpu_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO holding {pc, instr} fetch results.
//   clk, reset - clock and asynchronous active-low reset
//   push       - write push_data at the tail
//   push_data  - {pc, instr} payload
//   pop        - drop the head entry
//   clear      - empty the FIFO (takes priority over push/pop)
//   head       - head entry, zero when empty
//   empty/full - occupancy flags
//   count      - number of valid entries (0..2)
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         clear,
    output fetch_entry_t head,
    output logic         empty,
    output logic         full,
    output logic [1:0]   count
);

    fetch_entry_t [1:0] mem_q;
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [1:0]         count_q;
    logic               do_push;
    logic               do_pop;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clear) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch unit, producing end of the IF/ID register.
//   RESET_PC    - first fetch address after reset
//   clk, reset  - clock and asynchronous active-low reset
//   imem        - instruction memory req/gnt/rvalid bus (master side)
//   redirect    - taken branch/jump from EX; flushes and refetches from redirect_pc
//   redirect_pc - redirect target, low two bits ignored
//   stall       - IF/ID holds; nothing is handed over this cycle
//   out_instr   - instruction to IF/ID (zero when nothing buffered)
//   out_pc      - PC of out_instr (zero when nothing buffered)
//   out_valid   - hand-over strobe; the buffered head is consumed when high
//   out_flush   - IF/ID flush, high in the redirect cycle
module if_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    if_fetch_if.master        imem,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              stall,
    output logic [XLEN-1:0]   out_instr,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_valid,
    output logic              out_flush
);

    logic [XLEN-1:0]       pc_fetch_q, pc_fetch_d;
    logic [1:0]            outstanding_q, outstanding_d;
    logic [1:0]            kill_cnt_q, kill_cnt_d;
    // PCs of granted requests awaiting rvalid; entry 0 is the oldest.
    logic [1:0][XLEN-1:0]  inflight_q, inflight_d;

    fetch_entry_t fifo_head;
    fetch_entry_t fifo_push_data;
    logic         fifo_empty;
    logic         fifo_full;
    logic [1:0]   fifo_count;
    logic         fifo_push;
    logic         fifo_pop;
    logic         resp_live;
    logic [2:0]   slots_used;
    logic [1:0]   inflight_slot;

    fetch_fifo u_fetch_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .clear     (redirect),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty && !stall && !redirect;
    assign fifo_pop  = out_valid;
    assign out_instr = fifo_head.instr;
    assign out_pc    = fifo_head.pc;
    // Gated by reset so the flush strobe reads 0 while reset is held.
    assign out_flush = redirect && reset;

    // Requests in flight plus buffered entries may not exceed the two buffer
    // slots; a head leaving this cycle frees its slot, which keeps the
    // pipeline at one instruction per cycle.
    assign slots_used = {1'b0, outstanding_q} + {1'b0, fifo_count} - {2'b00, fifo_pop};
    assign imem.req   = reset && !redirect && (slots_used < 3'd2);
    assign imem.addr  = pc_fetch_q;

    // Responses to requests issued before a redirect are dropped.
    assign resp_live      = imem.rvalid && (kill_cnt_q == 2'd0) && !redirect;
    assign fifo_push      = resp_live && (!fifo_full || fifo_pop);
    assign fifo_push_data = '{pc: inflight_q[0], instr: imem.rdata};

    always_comb begin
        outstanding_d = outstanding_q + {1'b0, imem.gnt} - {1'b0, imem.rvalid};

        kill_cnt_d = kill_cnt_q;
        if (redirect) begin
            // Everything still in flight after this cycle, including a
            // same-cycle grant, belongs to the old path.
            kill_cnt_d = outstanding_d;
        end else if (imem.rvalid && (kill_cnt_q != 2'd0)) begin
            kill_cnt_d = kill_cnt_q - 2'd1;
        end

        pc_fetch_d = pc_fetch_q;
        if (redirect) begin
            pc_fetch_d = align_word(redirect_pc);
        end else if (imem.gnt) begin
            pc_fetch_d = pc_fetch_q + PC_STEP;
        end

        inflight_d    = inflight_q;
        inflight_slot = outstanding_q - {1'b0, imem.rvalid};
        if (imem.rvalid) begin
            inflight_d[0] = inflight_q[1];
        end
        if (imem.gnt) begin
            if (inflight_slot == 2'd0) begin
                inflight_d[0] = pc_fetch_q;
            end else begin
                inflight_d[1] = pc_fetch_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_fetch_q    <= RESET_PC;
            outstanding_q <= 2'd0;
            kill_cnt_q    <= 2'd0;
            inflight_q    <= '0;
        end else begin
            pc_fetch_q    <= pc_fetch_d;
            outstanding_q <= outstanding_d;
            kill_cnt_q    <= kill_cnt_d;
            inflight_q    <= inflight_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: self-checking bench for if_fetch with a behavioural
// instruction memory of configurable latency and a delivery scoreboard.
module tb_if_fetch;
    import cpu_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_valid;
    logic        out_flush;
    logic        gnt_en = 1'b1;
    logic        force_gnt = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] exp_next = '0;
    logic [31:0] tgt_pc = '0;
    logic        first_tgt_pending = 1'b0;
    logic        wrap_pending = 1'b0;
    logic        wrap_seen = 1'b0;

    // Values sampled by the last tick, for directed checks.
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic        s_flush;

    exp_t  sb[$];
    mreq_t mq[$];

    always #5 clk = ~clk;

    if_fetch_if bus ();

    assign bus.gnt = (bus.req && gnt_en) || force_gnt;

    if_fetch #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_valid   (out_valid),
        .out_flush   (out_flush)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample/check at negedge, then update memory after posedge.
    task automatic tick();
        exp_t  e;
        mreq_t m;
        @(negedge clk);
        s_req   = bus.req;
        s_addr  = bus.addr;
        s_valid = out_valid;
        s_pc    = out_pc;
        s_flush = out_flush;
        check_eq("out_flush", out_flush, redirect);
        if (stall || redirect) check_eq("valid_blocked", out_valid, 0);
        if (bus.req) check_eq("addr_align", bus.addr[1:0], 0);
        if (wrap_pending) begin
            check_eq("wrap_addr", bus.addr, 0);
            wrap_pending = 1'b0;
            wrap_seen    = 1'b1;
        end
        if (redirect) begin
            sb.delete();
            exp_next          = {redirect_pc[31:2], 2'b00};
            tgt_pc            = exp_next;
            first_tgt_pending = 1'b1;
        end else if (out_valid) begin
            check_eq("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("sb_pc", out_pc, e.pc);
                check_eq("sb_instr", out_instr, e.instr);
            end
            check_eq("pc_seq", out_pc, exp_next);
            exp_next = exp_next + 32'd4;
            if (first_tgt_pending) begin
                check_eq("first_after_redir", out_pc, tgt_pc);
                first_tgt_pending = 1'b0;
            end
        end
        if (bus.gnt) begin
            mq.push_back('{addr: bus.addr, due: cyc + lat});
            if (!redirect) begin
                sb.push_back('{pc: bus.addr, instr: instr_of(bus.addr)});
                if (bus.addr == 32'hFFFF_FFFC) wrap_pending = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            bus.rvalid = 1'b1;
            bus.rdata  = instr_of(m.addr);
        end else begin
            bus.rvalid = 1'b0;
            bus.rdata  = '0;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_req"}, bus.req, 0);
        check_eq({pfx, "_addr"}, bus.addr, 32'h0000_0000);
        check_eq({pfx, "_valid"}, out_valid, 0);
        check_eq({pfx, "_flush"}, out_flush, 0);
        check_eq({pfx, "_instr"}, out_instr, 0);
        check_eq({pfx, "_pc"}, out_pc, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        reset    = 1'b1;
        cyc      = 0;
        exp_next = 32'h0000_0000;

        // First request and fetch latency: out_pc 0,4,8,12 from cycle 2.
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                check_eq("first_req", s_req, 1);
                check_eq("first_addr", s_addr, 32'h0000_0000);
            end
            if (k < 2) begin
                check_eq("early_valid", s_valid, 0);
            end else begin
                check_eq("stream_valid", s_valid, 1);
                check_eq("stream_pc", s_pc, 32'(4 * (k - 2)));
            end
        end

        // Stall for 5 cycles: buffer fills, requests stop, head delivered on release.
        repeat (2) tick();
        stall = 1'b1;
        repeat (5) tick();
        check_eq("stall_req_drop", s_req, 0);
        stall = 1'b0;
        tick();
        check_eq("stall_release0", s_valid, 1);
        tick();
        check_eq("stall_release1", s_valid, 1);
        repeat (3) tick();

        // Redirect with two requests in flight on a slow memory.
        lat   = 3;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (mq.size() == 2 && bus.rvalid == 1'b0) found = 1'b1;
        end
        check_eq("inflight2_found", found, 1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        check_eq("redir_flush", s_flush, 1);
        check_eq("redir_valid", s_valid, 0);
        redirect = 1'b0;
        tick();
        check_eq("redir_addr", s_addr, 32'h0000_0100);
        repeat (12) tick();
        check_eq("redir_delivered", first_tgt_pending, 0);

        // Redirect coinciding with a grant of a stale address.
        lat = 1;
        repeat (4) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        force_gnt   = 1'b1;
        tick();
        force_gnt = 1'b0;
        redirect  = 1'b0;
        repeat (8) tick();
        check_eq("gnt_redir_delivered", first_tgt_pending, 0);

        // Address wrap from 0xFFFF_FFFC to 0.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        repeat (8) tick();
        check_eq("wrap_seen", wrap_seen, 1);

        // Reset asserted mid-stream with the buffer full.
        stall = 1'b1;
        repeat (4) tick();
        check_eq("pre_rst_req", s_req, 0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mrst");
        mq.delete();
        sb.delete();
        bus.rvalid        = 1'b0;
        bus.rdata         = '0;
        stall             = 1'b0;
        wrap_pending      = 1'b0;
        first_tgt_pending = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b1;
        exp_next = 32'h0000_0000;
        tick();
        check_eq("post_rst_req", s_req, 1);
        check_eq("post_rst_addr", s_addr, 32'h0000_0000);
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
